// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, padder state encoding and the word padding helper
// used by the message padder.
package sha1_pkg;

  localparam int SHA1_BLOCK_W          = 512;
  localparam int SHA1_WORD_W           = 32;
  localparam int SHA1_BLOCK_WORDS      = SHA1_BLOCK_W / SHA1_WORD_W;
  localparam logic [7:0] SHA1_PAD_BYTE = 8'h80;
  localparam int SHA1_LEN_OFFSET_BYTES = 56;

  localparam logic [SHA1_WORD_W-1:0] SHA1_PAD_WORD = {SHA1_PAD_BYTE, 24'h000000};

  typedef enum logic [2:0] {
    ST_FILL,
    ST_ISSUE,
    ST_GUARD,
    ST_WAIT,
    ST_EXTRA
  } padder_state_t;

  // Keep bytes [0..nbytes-1] (byte 0 in bits [31:24]), place 0x80 in byte
  // nbytes when the word is not full, and zero everything after it.
  function automatic logic [SHA1_WORD_W-1:0] sha1_pad_word(
    input logic [SHA1_WORD_W-1:0] data,
    input logic [2:0]             nbytes
  );
    logic [SHA1_WORD_W-1:0] w;
    w = '0;
    for (int b = 0; b < 4; b++) begin
      if (b < int'(nbytes)) begin
        w[31-8*b -: 8] = data[31-8*b -: 8];
      end else if (b == int'(nbytes)) begin
        w[31-8*b -: 8] = SHA1_PAD_BYTE;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/sha1_msg_padder.sv
// Assembles a 32-bit big-endian word stream into padded 512-bit SHA-1 blocks
// and hands them to sha1_core with init/next pulses paced by core_ready.
module sha1_msg_padder
  import sha1_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic         core_init,
  output logic         core_next,
  output logic [511:0] core_block,
  input  logic         core_ready,
  output logic         msg_done
);

  padder_state_t state_q, state_d;

  // Word i of the block lives in element 15-i so the packed vector matches
  // the core's layout (word 0 in the top 32 bits).
  logic [SHA1_BLOCK_WORDS-1:0][SHA1_WORD_W-1:0] blk_q;

  logic [3:0]       idx_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_inc;
  logic             first_q;
  logic             final_q;
  logic             extra_pending_q;
  logic             extra_pad_q;

  logic [3:0]       slot;
  logic             fits;
  logic             xfer;

  function automatic logic [63:0] len_field(input logic [LEN_W-1:0] l);
    logic [63:0] f;
    f = '0;
    f[LEN_W-1:0] = l;
    return f;
  endfunction

  assign slot    = ~idx_q;
  assign len_inc = len_q + LEN_W'({in_bytes, 3'b000});
  // The 0x80 byte must end at or before byte 56 for the length to share
  // this block; otherwise a trailing length-only block follows.
  assign fits    = (4 * int'(idx_q) + int'(in_bytes) + 1) <= SHA1_LEN_OFFSET_BYTES;
  assign xfer    = (state_q == ST_FILL) && in_valid;

  assign core_block = blk_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    core_init = 1'b0;
    core_next = 1'b0;
    msg_done  = 1'b0;
    case (state_q)
      ST_FILL: begin
        in_ready = 1'b1;
        if (in_valid && (in_last || idx_q == 4'd15)) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE, ST_EXTRA: begin
        if (core_ready) begin
          core_init = first_q;
          core_next = !first_q;
          state_d   = ST_GUARD;
        end
      end
      // The core may still report ready in the cycle after a pulse.
      ST_GUARD: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_ready) begin
          if (extra_pending_q) begin
            state_d = ST_EXTRA;
          end else begin
            msg_done = final_q;
            state_d  = ST_FILL;
          end
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_q           <= '0;
      idx_q           <= '0;
      len_q           <= '0;
      first_q         <= 1'b1;
      final_q         <= 1'b0;
      extra_pending_q <= 1'b0;
      extra_pad_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (xfer) begin
            blk_q[slot] <= sha1_pad_word(in_data, in_bytes);
            len_q       <= len_inc;
            idx_q       <= idx_q + 4'd1;
            if (in_last) begin
              if (in_bytes == 3'd4 && idx_q != 4'd15) begin
                blk_q[slot - 4'd1] <= SHA1_PAD_WORD;
              end
              if (fits) begin
                {blk_q[1], blk_q[0]} <= len_field(len_inc);
              end
              final_q         <= fits;
              extra_pending_q <= !fits;
              extra_pad_q     <= (in_bytes == 3'd4) && (idx_q == 4'd15);
            end else begin
              final_q <= 1'b0;
            end
          end
        end
        ST_ISSUE, ST_EXTRA: begin
          if (core_ready) begin
            first_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (core_ready) begin
            blk_q <= '0;
            if (extra_pending_q) begin
              blk_q[15]            <= extra_pad_q ? SHA1_PAD_WORD : '0;
              {blk_q[1], blk_q[0]} <= len_field(len_q);
              extra_pending_q      <= 1'b0;
              final_q              <= 1'b1;
            end else if (final_q) begin
              len_q   <= '0;
              idx_q   <= '0;
              first_q <= 1'b1;
            end else begin
              idx_q <= '0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Directed bench for sha1_msg_padder: padding boundaries, multi-block
// messages, core_ready back-pressure and asynchronous reset mid-message.
module tb_sha1_msg_padder;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic         core_init;
  logic         core_next;
  logic [511:0] core_block;
  logic         core_ready;
  logic         msg_done;

  int checks   = 0;
  int failures = 0;

  logic [511:0] exp_a;
  logic [511:0] exp_b;

  sha1_msg_padder #(.LEN_W(64)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_bytes   (in_bytes),
    .core_init  (core_init),
    .core_next  (core_next),
    .core_block (core_block),
    .core_ready (core_ready),
    .msg_done   (msg_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (in_valid && in_ready) begin
      assert (in_bytes <= 3'd4 && (in_last || in_bytes == 3'd4))
        else $error("illegal in_bytes=%0d last=%0b", in_bytes, in_last);
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic chkb(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [511:0] put(input logic [511:0] b, input int i, input logic [31:0] w);
    logic [511:0] r;
    r = b;
    r[511-32*i -: 32] = w;
    return r;
  endfunction

  function automatic logic [31:0] dw(input int i);
    return 32'h00010203 + 32'(i) * 32'h04040404;
  endfunction

  // Called and returns on a falling edge.
  task automatic send(input logic [31:0] d, input logic [2:0] b, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_bytes = b;
    in_last  = l;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk1("send_timeout", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Expects one block handoff with core_ready held high.
  task automatic expect_block(input logic init, input logic [511:0] blk,
                              input logic fin, input string tag);
    int n;
    n = 0;
    while (!(core_init || core_next) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk1({tag, "_init"}, core_init, init);
    chk1({tag, "_next"}, core_next, !init);
    chkb({tag, "_block"}, core_block, blk);
    @(negedge clk);
    chk1({tag, "_guard_quiet"}, core_init | core_next, 1'b0);
    @(negedge clk);
    chk1({tag, "_done"}, msg_done, fin);
    chkb({tag, "_block_held"}, core_block, blk);
    @(negedge clk);
  endtask

  initial begin
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_bytes   = '0;
    in_last    = 1'b0;
    core_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_core_init", core_init, 1'b0);
    chk1("rst_core_next", core_next, 1'b0);
    chkb("rst_core_block", core_block, '0);
    chk1("rst_msg_done", msg_done, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // "abc" with a junk fourth byte that must be replaced by 0x80
    exp_a = put('0, 0, 32'h61626380);
    exp_a = put(exp_a, 15, 32'h00000018);
    send(32'h616263FF, 3'd3, 1'b1);
    expect_block(1'b1, exp_a, 1'b1, "abc");

    // empty message
    exp_b = put('0, 0, 32'h80000000);
    send(32'hDEADBEEF, 3'd0, 1'b1);
    expect_block(1'b1, exp_b, 1'b1, "empty");

    // 55 bytes: 0x80 lands in byte 55, length still fits
    exp_b = '0;
    for (int i = 0; i < 13; i++) begin
      send(dw(i), 3'd4, 1'b0);
      exp_b = put(exp_b, i, dw(i));
    end
    send(dw(13), 3'd3, 1'b1);
    exp_b = put(exp_b, 13, 32'h34353680);
    exp_b = put(exp_b, 15, 32'h000001B8);
    expect_block(1'b1, exp_b, 1'b1, "len55");

    // 56 bytes: length spills into a second block
    exp_b = '0;
    for (int i = 0; i < 14; i++) begin
      send(dw(i), 3'd4, i == 13);
      exp_b = put(exp_b, i, dw(i));
    end
    exp_b = put(exp_b, 14, 32'h80000000);
    expect_block(1'b1, exp_b, 1'b0, "len56_b1");
    expect_block(1'b0, put('0, 15, 32'h000001C0), 1'b1, "len56_b2");

    // 64 bytes: 0x80 deferred to the extra block
    exp_b = '0;
    for (int i = 0; i < 16; i++) begin
      send(dw(i), 3'd4, i == 15);
      exp_b = put(exp_b, i, dw(i));
    end
    expect_block(1'b1, exp_b, 1'b0, "len64_b1");
    exp_b = put('0, 0, 32'h80000000);
    exp_b = put(exp_b, 15, 32'h00000200);
    expect_block(1'b0, exp_b, 1'b1, "len64_b2");

    // core_ready held low before and after the pulse
    core_ready = 1'b0;
    send(32'h61626300, 3'd3, 1'b1);
    for (int i = 0; i < 20; i++) begin
      chk1("hold_pre_no_pulse", core_init | core_next, 1'b0);
      chk1("hold_pre_in_ready", in_ready, 1'b0);
      chkb("hold_pre_block", core_block, exp_a);
      @(negedge clk);
    end
    core_ready = 1'b1;
    #1;
    chk1("hold_init", core_init, 1'b1);
    chk1("hold_next", core_next, 1'b0);
    chkb("hold_block", core_block, exp_a);
    @(negedge clk);
    core_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk1("hold_post_no_done", msg_done, 1'b0);
      chk1("hold_post_no_pulse", core_init | core_next, 1'b0);
      chk1("hold_post_in_ready", in_ready, 1'b0);
      chkb("hold_post_block", core_block, exp_a);
      @(negedge clk);
    end
    core_ready = 1'b1;
    #1;
    chk1("hold_done", msg_done, 1'b1);
    @(negedge clk);
    chk1("hold_back_to_fill", in_ready, 1'b1);
    chkb("hold_block_cleared", core_block, '0);

    // asynchronous reset partway through a message
    for (int i = 0; i < 7; i++) send(dw(i), 3'd4, 1'b0);
    chk1("midfill_block_loaded", core_block != '0, 1'b1);
    reset_n = 1'b0;
    #1;
    chk1("midrst_in_ready", in_ready, 1'b1);
    chkb("midrst_block", core_block, '0);
    chk1("midrst_no_pulse", core_init | core_next, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send(32'h61626300, 3'd3, 1'b1);
    expect_block(1'b1, exp_a, 1'b1, "abc_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
